// File: rtl/jtpopeye_ioctl_tx.sv
// ROM download transmitter: pulls bytes from a valid/ready source and
// drives the ioctl bus with paced one-cycle write strobes.
// Ports: clk_rom, rst (sync, high), start, src_data/src_valid/src_ready,
//        downloading, ioctl_addr, ioctl_data, ioctl_wr, done, chksum.
module jtpopeye_ioctl_tx #(
  parameter logic [21:0] ROM_LEN = 22'd74752,
  parameter int          WR_GAP  = 4,
  parameter int          TAIL    = 8
) (
  input  logic        clk_rom,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic        downloading,
  output logic [21:0] ioctl_addr,
  output logic [7:0]  ioctl_data,
  output logic        ioctl_wr,
  output logic        done,
  output logic [7:0]  chksum
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_STROBE = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [3:0]  GAP_LD  = 4'(WR_GAP);
  localparam logic [7:0]  TAIL_LD = 8'(TAIL);
  localparam logic [21:0] LAST    = ROM_LEN - 22'd1;

  logic [2:0] state;
  logic [3:0] gap_cnt;
  logic [7:0] tail_cnt;
  logic       last;
  logic       adv;

  assign src_ready = (state == S_FETCH);
  assign last      = (ioctl_addr == LAST);

  // Leave the strobe/gap phase: straight from STROBE when there is
  // no gap, otherwise on the final gap cycle.
  assign adv = ((state == S_STROBE) && (GAP_LD == 4'd0)) ||
               ((state == S_GAP) && (gap_cnt <= 4'd1));

  always_ff @(posedge clk_rom) begin
    if (rst) begin
      state       <= S_IDLE;
      gap_cnt     <= 4'd0;
      tail_cnt    <= 8'd0;
      downloading <= 1'b0;
      ioctl_addr  <= 22'd0;
      ioctl_data  <= 8'd0;
      ioctl_wr    <= 1'b0;
      done        <= 1'b0;
      chksum      <= 8'd0;
    end else begin
      ioctl_wr <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_FETCH;
            downloading <= 1'b1;
            ioctl_addr  <= 22'd0;
            chksum      <= 8'd0;
          end
        end
        S_FETCH: begin
          if (src_valid) begin
            ioctl_data <= src_data;
            state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          // Registered, so the strobe is high during STROBE.
          ioctl_wr <= 1'b1;
          state    <= S_STROBE;
        end
        S_STROBE: begin
          chksum  <= chksum + ioctl_data;
          gap_cnt <= GAP_LD;
          if (!adv) state <= S_GAP;
        end
        S_GAP: begin
          if (!adv) gap_cnt <= gap_cnt - 4'd1;
        end
        S_FINISH: begin
          if (tail_cnt <= 8'd1) begin
            downloading <= 1'b0;
            done        <= 1'b1;
            state       <= S_IDLE;
          end else begin
            tail_cnt <= tail_cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (adv) begin
        if (last) begin
          state    <= S_FINISH;
          tail_cnt <= TAIL_LD;
        end else begin
          ioctl_addr <= ioctl_addr + 22'd1;
          state      <= S_FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtpopeye_ioctl_tx.sv
// Directed bench for jtpopeye_ioctl_tx: three configurations
// (4/2/4, 3/0/4, 1/2/4) driven from one linear sequence.
module tb_jtpopeye_ioctl_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  // ---- dut0: ROM_LEN=4, WR_GAP=2, TAIL=4
  logic start0, valid0, ready0, dl0, wr0, done0;
  logic [7:0] sd0, data0, cs0;
  logic [21:0] addr0;
  int acc0 = 0, base0 = 0;
  logic [1:0] sel0;
  assign sel0 = acc0[1:0] - base0[1:0];
  assign sd0 = bytes[sel0];

  jtpopeye_ioctl_tx #(.ROM_LEN(22'd4), .WR_GAP(2), .TAIL(4)) u0 (
    .clk_rom(clk), .rst(rst), .start(start0), .src_data(sd0),
    .src_valid(valid0), .src_ready(ready0), .downloading(dl0),
    .ioctl_addr(addr0), .ioctl_data(data0), .ioctl_wr(wr0),
    .done(done0), .chksum(cs0));

  // ---- dut1: ROM_LEN=3, WR_GAP=0, TAIL=4
  logic start1, valid1, ready1, dl1, wr1, done1;
  logic [7:0] sd1, data1, cs1;
  logic [21:0] addr1;
  int acc1 = 0;
  assign sd1 = bytes[acc1[1:0]];

  jtpopeye_ioctl_tx #(.ROM_LEN(22'd3), .WR_GAP(0), .TAIL(4)) u1 (
    .clk_rom(clk), .rst(rst), .start(start1), .src_data(sd1),
    .src_valid(valid1), .src_ready(ready1), .downloading(dl1),
    .ioctl_addr(addr1), .ioctl_data(data1), .ioctl_wr(wr1),
    .done(done1), .chksum(cs1));

  // ---- dut2: ROM_LEN=1, WR_GAP=2, TAIL=4
  logic start2, valid2, ready2, dl2, wr2, done2;
  logic [7:0] sd2, data2, cs2;
  logic [21:0] addr2;
  int acc2 = 0;
  assign sd2 = (acc2 == 0) ? 8'hFF : 8'h01;

  jtpopeye_ioctl_tx #(.ROM_LEN(22'd1), .WR_GAP(2), .TAIL(4)) u2 (
    .clk_rom(clk), .rst(rst), .start(start2), .src_data(sd2),
    .src_valid(valid2), .src_ready(ready2), .downloading(dl2),
    .ioctl_addr(addr2), .ioctl_data(data2), .ioctl_wr(wr2),
    .done(done2), .chksum(cs2));

  // source handshake counters
  always @(posedge clk) begin
    if (!rst && valid0 && ready0) acc0 <= acc0 + 1;
    if (!rst && valid1 && ready1) acc1 <= acc1 + 1;
    if (!rst && valid2 && ready2) acc2 <= acc2 + 1;
  end

  // strobe logs
  logic [21:0] la0 [64];
  logic [7:0]  ld0 [64];
  int          lc0 [64];
  int n0 = 0, nd0 = 0, adj0 = 0, fall0 = 0;
  logic pwr0 = 1'b0, pdl0 = 1'b0;
  logic [21:0] la1 [8];
  logic [7:0]  ld1 [8];
  int          lc1 [8];
  int n1 = 0, nd1 = 0, adj1 = 0;
  logic pwr1 = 1'b0;
  logic [21:0] la2 [8];
  logic [7:0]  ld2 [8];
  int n2 = 0, nd2 = 0;

  always @(negedge clk) begin
    if (wr0) begin
      if (n0 < 64) begin
        la0[n0] <= addr0;
        ld0[n0] <= data0;
        lc0[n0] <= cyc;
      end
      n0 <= n0 + 1;
    end
    if (wr0 && pwr0) adj0 <= adj0 + 1;
    pwr0 <= wr0;
    if (done0) nd0 <= nd0 + 1;
    if (pdl0 && !dl0) fall0 <= cyc;
    pdl0 <= dl0;
    if (wr1) begin
      if (n1 < 8) begin
        la1[n1] <= addr1;
        ld1[n1] <= data1;
        lc1[n1] <= cyc;
      end
      n1 <= n1 + 1;
    end
    if (wr1 && pwr1) adj1 <= adj1 + 1;
    pwr1 <= wr1;
    if (done1) nd1 <= nd1 + 1;
    if (wr2) begin
      if (n2 < 8) begin
        la2[n2] <= addr2;
        ld2[n2] <= data2;
      end
      n2 <= n2 + 1;
    end
    if (done2) nd2 <= nd2 + 1;
  end

  int b, bd, ks, seen;

  initial begin
    rst = 1'b1;
    start0 = 0; start1 = 0; start2 = 0;
    valid0 = 0; valid1 = 0; valid2 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dl", dl0, 0);
    chk("rst_wr", wr0, 0);
    chk("rst_done", done0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_data", data0, 0);
    chk("rst_cs", cs0, 0);
    chk("rst_ready", ready0, 0);
    @(posedge clk); #1 rst = 1'b0;

    // ---- 1: basic download, valid held high
    base0 = acc0; b = n0; bd = nd0;
    valid0 = 1;
    @(posedge clk); #1 start0 = 1;
    @(posedge clk); #1 start0 = 0; ks = cyc;
    chk("t1_dl_on", dl0, 1);
    chk("t1_ready_on", ready0, 1);
    chk("t1_cs0", cs0, 0);
    for (int i = 0; i < 300 && nd0 == bd; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t1_done", nd0 - bd, 1);
    chk("t1_nstrobe", n0 - b, 4);
    chk("t1_lat", lc0[b] - ks, 2);
    for (int k = 0; k < 4; k++) begin
      chk("t1_addr", la0[b+k], k);
      chk("t1_data", ld0[b+k], bytes[k]);
    end
    for (int k = 1; k < 4; k++)
      chk("t1_space", lc0[b+k] - lc0[b+k-1], 5);
    chk("t1_fall", fall0 - lc0[b+3], 7);
    chk("t1_cs", cs0, 8'hAA);
    chk("t1_dl_off", dl0, 0);
    chk("t1_adj", adj0, 0);
    chk("t1_acc", acc0 - base0, 4);

    // ---- 2: source stall before byte 2
    base0 = acc0; b = n0; bd = nd0;
    valid0 = 1;
    @(posedge clk); #1 start0 = 1;
    @(posedge clk); #1 start0 = 0;
    for (int i = 0; i < 100 && acc0 - base0 < 2; i++) @(negedge clk);
    valid0 = 0;
    chk("t2_acc2", acc0 - base0, 2);
    repeat (10) @(negedge clk);
    chk("t2_stall_n", n0 - b, 2);
    chk("t2_stall_acc", acc0 - base0, 2);
    chk("t2_stall_rdy", ready0, 1);
    chk("t2_stall_wr", wr0, 0);
    valid0 = 1;
    for (int i = 0; i < 300 && nd0 == bd; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t2_nstrobe", n0 - b, 4);
    chk("t2_addr2", la0[b+2], 2);
    chk("t2_data2", ld0[b+2], 8'h33);
    chk("t2_cs", cs0, 8'hAA);
    chk("t2_done", nd0 - bd, 1);

    // ---- 3: WR_GAP=0, ROM_LEN=3
    valid1 = 1;
    @(posedge clk); #1 start1 = 1;
    @(posedge clk); #1 start1 = 0;
    for (int i = 0; i < 300 && nd1 == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t3_nstrobe", n1, 3);
    chk("t3_space1", lc1[1] - lc1[0], 3);
    chk("t3_space2", lc1[2] - lc1[1], 3);
    chk("t3_adj", adj1, 0);
    chk("t3_addr2", la1[2], 2);
    chk("t3_data2", ld1[2], 8'h33);
    chk("t3_cs", cs1, 8'h66);
    chk("t3_done", nd1, 1);

    // ---- 4: start during GAP and FINISH is ignored
    base0 = acc0; b = n0; bd = nd0;
    valid0 = 1;
    @(posedge clk); #1 start0 = 1;
    @(posedge clk); #1 start0 = 0;
    for (int i = 0; i < 100 && !wr0; i++) @(negedge clk);
    chk("t4_wr_seen", wr0, 1);
    @(posedge clk); #1 start0 = 1;
    @(posedge clk); #1 start0 = 0;
    for (int i = 0; i < 300 && n0 - b < 4; i++) @(negedge clk);
    repeat (3) @(posedge clk);
    #1 start0 = 1;
    chk("t4_in_finish", dl0 && !ready0, 1);
    @(posedge clk); #1 start0 = 0;
    for (int i = 0; i < 300 && nd0 == bd; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    chk("t4_nstrobe", n0 - b, 4);
    chk("t4_done", nd0 - bd, 1);
    chk("t4_dl_off", dl0, 0);
    chk("t4_ready_off", ready0, 0);
    chk("t4_acc", acc0 - base0, 4);

    // ---- 5: reset mid-download, then restart
    base0 = acc0; b = n0;
    valid0 = 1;
    @(posedge clk); #1 start0 = 1;
    @(posedge clk); #1 start0 = 0;
    seen = 0;
    for (int i = 0; i < 200 && seen < 2; i++) begin
      @(negedge clk);
      if (wr0) seen++;
    end
    chk("t5_seen2", seen, 2);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("t5_dl", dl0, 0);
    chk("t5_wr", wr0, 0);
    chk("t5_done", done0, 0);
    chk("t5_addr", addr0, 0);
    chk("t5_data", data0, 0);
    chk("t5_cs", cs0, 0);
    chk("t5_ready", ready0, 0);
    base0 = acc0; b = n0; bd = nd0;
    @(posedge clk); #1 start0 = 1;
    @(posedge clk); #1 start0 = 0;
    chk("t5_restart_dl", dl0, 1);
    chk("t5_restart_addr", addr0, 0);
    for (int i = 0; i < 300 && nd0 == bd; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t5_nstrobe", n0 - b, 4);
    chk("t5_addr0", la0[b], 0);
    chk("t5_data0", ld0[b], 8'h11);
    chk("t5_addr3", la0[b+3], 3);
    chk("t5_cs_end", cs0, 8'hAA);
    chk("t5_done_n", nd0 - bd, 1);

    // ---- 6: ROM_LEN=1, second byte not consumed
    valid2 = 1;
    @(posedge clk); #1 start2 = 1;
    @(posedge clk); #1 start2 = 0;
    for (int i = 0; i < 300 && nd2 == 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("t6_nstrobe", n2, 1);
    chk("t6_addr", la2[0], 0);
    chk("t6_data", ld2[0], 8'hFF);
    chk("t6_cs", cs2, 8'hFF);
    chk("t6_acc", acc2, 1);
    chk("t6_ready", ready2, 0);
    chk("t6_done", nd2, 1);
    chk("t6_dl_off", dl2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
